// File: rtl/approx_mult_pkg.sv
// Shared types and 1-bit adder cell functions for the iterative approximate multiplier.
package approx_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product width of the default 8x8 configuration
  localparam int PROD_W = 16;

  // approx_fa_21_107: exact sum except X=Y=1 gives S=1 and drops the generated carry
  function automatic logic approx_fa_s(input logic x, input logic y, input logic z);
    return (~x & ~y & z) | (~x & y & ~z) | (x & ~y & ~z) | (x & y);
  endfunction

  function automatic logic approx_fa_c(input logic x, input logic y, input logic z);
    return z & (x | y);
  endfunction

  function automatic logic exact_fa_s(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic exact_fa_c(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/approx_row_adder.sv
// Combinational ripple adder adding one shifted partial-product row into the accumulator,
// with approximate cells in the low APPROX_COLS columns unless exact is set.
module approx_row_adder
  import approx_mult_pkg::*;
#(
  parameter int W           = PROD_W,
  parameter int APPROX_COLS = 6,
  parameter int START_W     = 3
) (
  input  logic [W-1:0]       acc,
  input  logic [W-1:0]       row,
  input  logic [START_W-1:0] start,
  input  logic               exact,
  output logic [W-1:0]       sum
);

  logic carry;
  logic s_bit;
  logic c_bit;

  // Columns below start pass through; the carry chain begins with 0 at start.
  always_comb begin
    sum   = acc;
    carry = 1'b0;
    s_bit = 1'b0;
    c_bit = 1'b0;
    for (int c = 0; c < W; c++) begin
      if (c >= int'(start)) begin
        if ((c < APPROX_COLS) && !exact) begin
          s_bit = approx_fa_s(acc[c], row[c], carry);
          c_bit = approx_fa_c(acc[c], row[c], carry);
        end else begin
          s_bit = exact_fa_s(acc[c], row[c], carry);
          c_bit = exact_fa_c(acc[c], row[c], carry);
        end
        sum[c] = s_bit;
        carry  = c_bit;
      end
    end
  end

endmodule

// File: rtl/approx_mult_seq.sv
// Iterative approximate multiplier: one partial-product row per cycle, valid/ready on both sides.
// Optional APPROX_MULT_ERR_EN adds a shadow exact accumulator and err_o/err_nz_o outputs.
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH_A     = 8,
  parameter int WIDTH_B     = 8,
  parameter int APPROX_COLS = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a_i,
  input  logic [WIDTH_B-1:0]         b_i,
  input  logic                       exact_i,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] p_o
`ifdef APPROX_MULT_ERR_EN
  ,
  output logic signed [WIDTH_A+WIDTH_B:0] err_o,
  output logic                            err_nz_o
`endif
);

  localparam int P     = WIDTH_A + WIDTH_B;
  localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;

  state_t             state, state_nx;
  logic [WIDTH_A-1:0] a_q;
  logic [WIDTH_B-1:0] b_q;
  logic               exact_q;
  logic [P-1:0]       acc, acc_nx, row;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               last_row;

  assign last_row = (cnt == CNT_W'(WIDTH_B - 1));
  assign row      = {{WIDTH_B{1'b0}}, a_q & {WIDTH_A{b_q[cnt]}}} << cnt;

  approx_row_adder #(
    .W          (P),
    .APPROX_COLS(APPROX_COLS),
    .START_W    (CNT_W)
  ) u_row (
    .acc  (acc),
    .row  (row),
    .start(cnt),
    .exact(exact_q),
    .sum  (acc_nx)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (last_row) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = RUN;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // No new operands are advertised while reset is held
    if (!rst_n) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      exact_q <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q     <= a_i;
        b_q     <= b_i;
        exact_q <= exact_i;
        acc     <= '0;
        cnt     <= '0;
      end else if (state == RUN) begin
        acc <= acc_nx;
        cnt <= last_row ? '0 : cnt + 1'b1;
      end
    end
  end

  // The running accumulator is only exposed once the product is complete
  assign p_o = out_valid ? acc : '0;

`ifdef APPROX_MULT_ERR_EN
  logic [P-1:0] acc_ex, acc_ex_nx;

  approx_row_adder #(
    .W          (P),
    .APPROX_COLS(APPROX_COLS),
    .START_W    (CNT_W)
  ) u_row_ex (
    .acc  (acc_ex),
    .row  (row),
    .start(cnt),
    .exact(1'b1),
    .sum  (acc_ex_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_ex <= '0;
    end else if (accept) begin
      acc_ex <= '0;
    end else if (state == RUN) begin
      acc_ex <= acc_ex_nx;
    end
  end

  assign err_o    = out_valid ? ($signed({1'b0, acc_ex}) - $signed({1'b0, acc})) : '0;
  assign err_nz_o = |err_o;
`endif

endmodule

// File: tb/tb_approx_mult_seq.sv
// Randomised self-checking bench for approx_mult_seq (default 8x8, APPROX_COLS=6).
module tb_approx_mult_seq;

  localparam int WA = 8;
  localparam int WB = 8;
  localparam int AC = 6;
  localparam int PW = WA + WB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] a_i;
  logic [WB-1:0] b_i;
  logic          exact_i;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p_o;
`ifdef APPROX_MULT_ERR_EN
  logic signed [PW:0] err_o;
  logic               err_nz_o;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  approx_mult_seq #(
    .WIDTH_A    (WA),
    .WIDTH_B    (WB),
    .APPROX_COLS(AC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_i      (a_i),
    .b_i      (b_i),
    .exact_i  (exact_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p_o      (p_o)
`ifdef APPROX_MULT_ERR_EN
    ,
    .err_o    (err_o),
    .err_nz_o (err_nz_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Product as the column cells would produce it: each row is added bit by bit from its
  // own column upward using the exact or the approximate cell truth table.
  function automatic int ref_mult(input int a, input int b, input bit ex);
    int acc, rowv, nacc, x, y, z, s, co, tot;
    acc = 0;
    for (int i = 0; i < WB; i++) begin
      rowv = ((b >> i) & 1) ? (a << i) : 0;
      nacc = acc;
      z = 0;
      for (int c = i; c < PW; c++) begin
        x   = (acc >> c) & 1;
        y   = (rowv >> c) & 1;
        tot = x + y + z;
        if (!ex && c < AC) begin
          s  = ((tot == 1) || (x == 1 && y == 1)) ? 1 : 0;
          co = (z == 1 && (x == 1 || y == 1)) ? 1 : 0;
        end else begin
          s  = tot % 2;
          co = tot / 2;
        end
        nacc = (nacc & ~(1 << c)) | (s << c);
        z = co;
      end
      acc = nacc;
    end
    return acc;
  endfunction

  task automatic check_result(input string tag, input int a, input int b, input bit ex);
    int expv;
    expv = ex ? a * b : ref_mult(a, b, ex);
    check_val({tag, "_p"}, longint'(p_o), longint'(expv));
`ifdef APPROX_MULT_ERR_EN
    check_val({tag, "_err"}, longint'(err_o), longint'(a * b - expv));
    check_val({tag, "_errnz"}, longint'(err_nz_o), longint'((a * b) != expv));
`endif
  endtask

  task automatic run_op(input string tag, input int a, input int b, input bit ex,
                        input int stall, output int lat, output int prod);
    int n;
    a_i      = WA'(a);
    b_i      = WB'(b);
    exact_i  = ex;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    a_i      = WA'($urandom);
    b_i      = WB'($urandom);
    exact_i  = $urandom_range(0, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_val({tag, "_lat"}, lat, WB);
    prod = int'(p_o);
    check_result(tag, a, b, ex);
    for (int k = 0; k < stall; k++) begin
      tick();
      check_val({tag, "_hold"}, longint'(p_o), longint'(prod));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, prod, a, b, vcnt;
    bit ex;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    exact_i   = 1'b0;
    tick();
    tick();
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_p_o", p_o, 0);
    check_val("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_val("idle_in_ready", in_ready, 1);

    run_op("exact_255", 255, 255, 1'b1, 0, lat, prod);
    check_val("exact_255_val", prod, 65025);
    run_op("approx_3x3", 3, 3, 1'b0, 2, lat, prod);
    check_val("approx_3x3_val", prod, 7);
    run_op("zero_a", 0, 200, 1'b0, 0, lat, prod);
    run_op("zero_b", 77, 0, 1'b0, 1, lat, prod);
    run_op("approx_255", 255, 255, 1'b0, 0, lat, prod);

    for (int t = 0; t < 120; t++) begin
      a  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 255));
      b  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 255));
      ex = $urandom_range(0, 1);
      run_op("rand", a, b, ex, int'($urandom_range(0, 3)), lat, prod);
    end

    // Back-to-back: stall in DONE, then release and accept in the same cycle
    a_i = 8'd200; b_i = 8'd100; exact_i = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_val("b2b_first_lat", lat, WB);
    check_result("b2b_first", 200, 100, 1'b0);
    prod = int'(p_o);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("b2b_hold_p", longint'(p_o), longint'(prod));
      check_val("b2b_hold_in_ready", in_ready, 0);
      check_val("b2b_hold_valid", out_valid, 1);
    end
    a_i = 8'd13; b_i = 8'd17; exact_i = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_val("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check_val("b2b_run_valid", out_valid, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_val("b2b_second_lat", lat, WB);
    check_val("b2b_second_p", longint'(p_o), 221);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during RUN discards the operation
    a_i = 8'd99; b_i = 8'd201; exact_i = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_val("midrst_valid", out_valid, 0);
    check_val("midrst_p_o", p_o, 0);
    check_val("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check_val("midrst_idle", in_ready, 1);
    vcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (out_valid) vcnt++;
    end
    check_val("midrst_no_stale", vcnt, 0);
    run_op("after_rst", 21, 12, 1'b1, 0, lat, prod);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
